sprite_motion_ctrl: RTL and testbench
=====================================

Name: sprite_motion_ctrl

Overview:
Parametrised per-sprite motion engine for the game-engine animation layer. Generates one object's top-left screen coordinates, in one of two modes selected at run time:
- PLAYER: driven by a 4-bit direction input.
- BOUNCE: autonomous diagonal motion, reversing at the edges.
Positions advance only on a frame-rate tick. Edge-hit events are reported to game logic. One instance per moving object feeds the renderer's X/Y coordinate inputs.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
OBJ_W, 155, object width in pixels
OBJ_H, 82, object height in pixels
POS_W, 10, coordinate width; must satisfy 2^POS_W > max(SCREEN_W, SCREEN_H)
SPEED, 5, pixels moved per tick per axis; 1..min(MAXX, MAXY)
INIT_X, 0, reset X position; must be <= MAXX
INIT_Y, 0, reset Y position; must be <= MAXY

Ports:
CLOCK  in  1  system clock; all state updates on the falling edge
RESET  in  1  synchronous, active-high reset
tick  in  1  one-cycle frame-update strobe
mode  in  1  0 = PLAYER, 1 = BOUNCE
dirs  in  4  bit0 up, bit1 left, bit2 down, bit3 right; PLAYER mode only
posX  out  POS_W  object X coordinate, registered
posY  out  POS_W  object Y coordinate, registered
edgeHit  out  4  one-cycle pulses; bit0 top, bit1 left, bit2 bottom, bit3 right
moving  out  1  high when the last tick changed posX or posY

Behaviour:
- Derived limits: MAXX = SCREEN_W-OBJ_W; MAXY = SCREEN_H-OBJ_H. Internal arithmetic is POS_W+1 bits, so no underflow or overflow wrap is possible.
- Reset (RESET high at a falling edge; overrides tick):
  - posX = INIT_X, posY = INIT_Y
  - xDir = 1 (+), yDir = 1 (+)
  - edgeHit = 0, moving = 0
  - FSM = PLAYER if mode = 0, else BOUNCE
- FSM states and transitions:
  - PLAYER -> BOUNCE: on a tick with mode = 1. On entry, xDir = yDir = 1. No motion on that tick.
  - BOUNCE -> PLAYER: on a tick with mode = 0. No motion on that tick.
  - mode changes between ticks are ignored until the next tick.
- Latency: the tick sampled at edge N updates posX, posY, edgeHit and moving at edge N. Values are visible from edge N until the next update. edgeHit is cleared at edge N+1.
- Without tick: posX and posY hold; edgeHit = 0.
- PLAYER mode, per tick:
  - left: nx = (x >= SPEED) ? x-SPEED : 0
  - right: nx = (x+SPEED <= MAXX) ? x+SPEED : MAXX
  - up and down: same rules on Y against MAXY
  - Opposite bits both set (up+down or left+right): that axis holds.
  - edgeHit bit pulses when the axis was commanded toward an edge and nx (or ny) equals that edge, including when the object already sits on the edge.
- BOUNCE mode, per tick, each axis independently:
  - Move SPEED in the current direction, clamped to [0, MAX].
  - If the clamped result equals the limit in the direction of travel: flip the direction and pulse the matching edgeHit bit.
  - Movement reverses on the following tick.
  - Simultaneous X and Y hits (corner): both bits pulse.
- moving = 1 when (nx != x) or (ny != y) on that tick; otherwise 0.

Optional Feature:
Macro: SPRITE_WRAP_EN
- Defined: in PLAYER mode, motion past an edge wraps to the opposite limit instead of clamping.
  - Left from x < SPEED gives MAXX; right from x+SPEED > MAXX gives 0. Y wraps the same way.
  - The edgeHit bit of the edge crossed still pulses.
  - BOUNCE mode is unchanged.
- Undefined: clamp behaviour as above; no wrap logic is synthesised.

Test Plan:
All scenarios use default parameters unless stated (MAXX = 485, MAXY = 398).
1. Reset: RESET = 1 for 2 cycles, tick = 1 -> posX = 0, posY = 0, edgeHit = 0, moving = 0; tick is ignored.
2. PLAYER, dirs = 1000, 100 ticks from x = 0:
   - after tick 97: posX = 485, edgeHit[3] pulses
   - ticks 98-100: posX stays 485, moving = 0, edgeHit[3] pulses each tick
3. PLAYER, INIT_X = 3, dirs = 0010, 1 tick -> posX = 0, edgeHit[1] = 1; next tick posX stays 0, never 1022.
   - With SPRITE_WRAP_EN: posX = 485 instead.
4. PLAYER, INIT_Y = 100, dirs = 0101 for 10 ticks -> posY = 100, moving = 0, edgeHit = 0.
5. BOUNCE, SPEED = 1, from (0,0), 398 ticks:
   - posY = 398, posX = 398, edgeHit[2] pulses
   - tick 399: posY = 397, posX = 399
   - tick 485: posX = 485, edgeHit[3] pulses
6. Mode switch: BOUNCE mid-travel, mode -> 0 between ticks:
   - next tick: no motion, FSM = PLAYER
   - later, mode -> 1: next tick no motion, then motion resumes in the +X/+Y direction

Source files
------------

// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: per-sprite PLAYER/BOUNCE motion engine with edge-hit pulses, updated on the falling clock edge.
// Define SPRITE_WRAP_EN to wrap PLAYER motion to the opposite limit instead of clamping.
module sprite_motion_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int OBJ_W = 155,
  parameter int OBJ_H = 82,
  parameter int POS_W = 10,
  parameter int SPEED = 5,
  parameter int INIT_X = 0,
  parameter int INIT_Y = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             tick,
  input  logic             mode,
  input  logic [3:0]       dirs,
  output logic [POS_W-1:0] posX,
  output logic [POS_W-1:0] posY,
  output logic [3:0]       edgeHit,
  output logic             moving
);
  localparam int AW = POS_W + 1;
  localparam logic [AW-1:0] MX = AW'(SCREEN_W - OBJ_W);
  localparam logic [AW-1:0] MY = AW'(SCREEN_H - OBJ_H);
  localparam logic [AW-1:0] SP = AW'(SPEED);
`ifdef SPRITE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  typedef enum logic {PLAYER, BOUNCE} stateT;
  stateT state, nextState;
  logic xDir, yDir, nxDir, nyDir, bounce, hx, hy;
  logic [AW:0] sx, sy;
  logic [AW-1:0] nx, ny;
  logic [3:0] hits;
  // {reached-or-crossed the edge in the travel direction, next coordinate}
  function automatic logic [AW:0] stepAxis(input logic [AW-1:0] p, input logic [AW-1:0] lim,
                                           input logic neg, input logic wrap);
    logic [AW-1:0] up;
    up = p + SP;
    return neg ? {p <= SP, p >= SP ? p - SP : (wrap ? lim : {AW{1'b0}})}
               : {up >= lim, up <= lim ? up : (wrap ? {AW{1'b0}} : lim)};
  endfunction
  always_comb begin
    bounce = state == BOUNCE;
    sx = stepAxis({1'b0, posX}, MX, bounce ? !xDir : dirs[1], WRAP && !bounce);
    sy = stepAxis({1'b0, posY}, MY, bounce ? !yDir : dirs[0], WRAP && !bounce);
    hx = dirs[1] ^ dirs[3];
    hy = dirs[0] ^ dirs[2];
    nextState = state;
    nx = {1'b0, posX};
    ny = {1'b0, posY};
    nxDir = xDir;
    nyDir = yDir;
    hits = 4'b0;
    if (bounce != mode) begin
      nextState = mode ? BOUNCE : PLAYER;
      nxDir = mode ? 1'b1 : xDir;
      nyDir = mode ? 1'b1 : yDir;
    end else if (bounce) begin
      nx = sx[AW-1:0];
      ny = sy[AW-1:0];
      nxDir = xDir ^ sx[AW];
      nyDir = yDir ^ sy[AW];
      hits = {xDir & sx[AW], yDir & sy[AW], !xDir & sx[AW], !yDir & sy[AW]};
    end else begin
      nx = hx ? sx[AW-1:0] : nx;
      ny = hy ? sy[AW-1:0] : ny;
      hits = {dirs[3] & hx & sx[AW], dirs[2] & hy & sy[AW], dirs[1] & hx & sx[AW], dirs[0] & hy & sy[AW]};
    end
  end
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      state <= mode ? BOUNCE : PLAYER;
      posX <= POS_W'(INIT_X);
      posY <= POS_W'(INIT_Y);
      xDir <= 1'b1;
      yDir <= 1'b1;
      edgeHit <= 4'b0;
      moving <= 1'b0;
    end else begin
      edgeHit <= tick ? hits : 4'b0;
      if (tick) begin
        state <= nextState;
        posX <= nx[POS_W-1:0];
        posY <= ny[POS_W-1:0];
        xDir <= nxDir;
        yDir <= nyDir;
        moving <= (nx != {1'b0, posX}) || (ny != {1'b0, posY});
      end
    end
  end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed checks of three sprite_motion_ctrl configurations sharing clock, reset and tick.
module tb_sprite_motion_ctrl;
  logic CLOCK = 1'b0, RESET = 1'b0, tick = 1'b0;
  logic modeA = 1'b0, modeB = 1'b0, modeC = 1'b1;
  logic [3:0] dirsA = 4'b0, dirsB = 4'b0, dirsC = 4'b0;
  logic [9:0] xA, yA, xB, yB, xC, yC;
  logic [3:0] hA, hB, hC;
  logic mA, mB, mC;
  int errors = 0, checks = 0;
  always #5 CLOCK = ~CLOCK;
  sprite_motion_ctrl dutA (.CLOCK(CLOCK), .RESET(RESET), .tick(tick), .mode(modeA), .dirs(dirsA),
    .posX(xA), .posY(yA), .edgeHit(hA), .moving(mA));
  sprite_motion_ctrl #(.INIT_X(3), .INIT_Y(100)) dutB (.CLOCK(CLOCK), .RESET(RESET), .tick(tick),
    .mode(modeB), .dirs(dirsB), .posX(xB), .posY(yB), .edgeHit(hB), .moving(mB));
  sprite_motion_ctrl #(.SPEED(1)) dutC (.CLOCK(CLOCK), .RESET(RESET), .tick(tick), .mode(modeC),
    .dirs(dirsC), .posX(xC), .posY(yC), .edgeHit(hC), .moving(mC));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // Inputs change on rising edges; the DUT acts on falling edges, so results are stable here.
  task automatic doTick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      tick = 1'b1;
      @(posedge CLOCK);
      tick = 1'b0;
    end
  endtask
  task automatic rst();
    @(posedge CLOCK);
    RESET = 1'b1;
    tick = 1'b1;
    repeat (2) @(posedge CLOCK);
    RESET = 1'b0;
    tick = 1'b0;
  endtask
  initial begin
    rst();
    chk("rst_x", xA, 0);
    chk("rst_y", yA, 0);
    chk("rst_hit", hA, 0);
    chk("rst_mov", mA, 0);
    chk("rst_initx", xB, 3);
    chk("rst_inity", yB, 100);
    dirsA = 4'b1000;
    for (int i = 1; i <= 100; i++) begin
      doTick(1);
      if (i == 96) begin
        chk("r96_x", xA, 480);
        chk("r96_hit", hA, 0);
        chk("r96_mov", mA, 1);
      end
      if (i == 97) begin
        chk("r97_x", xA, 485);
        chk("r97_hit", hA, 4'b1000);
        chk("r97_mov", mA, 1);
      end
      if (i >= 98) begin
        chk("rhold_x", xA, 485);
        chk("rhold_hit", hA, 4'b1000);
        chk("rhold_mov", mA, 0);
      end
    end
    chk("r_y", yA, 0);
    @(posedge CLOCK);
    chk("noTick_hit", hA, 0);
    chk("noTick_x", xA, 485);
    dirsA = 4'b0100;
    doTick(1);
    chk("down_y", yA, 5);
    chk("down_hit", hA, 0);
    dirsA = 4'b0001;
    doTick(1);
    chk("up_y", yA, 0);
    chk("up_hit", hA, 4'b0001);
    doTick(1);
    chk("upHold_y", yA, 0);
    chk("upHold_hit", hA, 4'b0001);
    chk("upHold_mov", mA, 0);
    dirsA = 4'b0011;
    doTick(1);
    chk("upLeft_x", xA, 480);
    chk("upLeft_hit", hA, 4'b0001);
    chk("upLeft_mov", mA, 1);
    dirsB = 4'b0010;
    rst();
    doTick(1);
`ifdef SPRITE_WRAP_EN
    chk("left3_x", xB, 485);
    chk("left3_hit", hB, 4'b0010);
    doTick(1);
    chk("left3b_x", xB, 480);
    chk("left3b_hit", hB, 0);
    chk("left3b_mov", mB, 1);
`else
    chk("left3_x", xB, 0);
    chk("left3_hit", hB, 4'b0010);
    doTick(1);
    chk("left3b_x", xB, 0);
    chk("left3b_hit", hB, 4'b0010);
    chk("left3b_mov", mB, 0);
`endif
    dirsB = 4'b0101;
    rst();
    doTick(10);
    chk("ud_y", yB, 100);
    chk("ud_x", xB, 3);
    chk("ud_mov", mB, 0);
    chk("ud_hit", hB, 0);
    dirsB = 4'b1010;
    doTick(1);
    chk("lr_x", xB, 3);
    chk("lr_hit", hB, 0);
    rst();
    doTick(398);
    chk("b398_y", yC, 398);
    chk("b398_x", xC, 398);
    chk("b398_hit", hC, 4'b0100);
    doTick(1);
    chk("b399_y", yC, 397);
    chk("b399_x", xC, 399);
    chk("b399_hit", hC, 0);
    doTick(86);
    chk("b485_x", xC, 485);
    chk("b485_y", yC, 311);
    chk("b485_hit", hC, 4'b1000);
    doTick(1);
    chk("b486_x", xC, 484);
    chk("b486_y", yC, 310);
    modeA = 1'b1;
    dirsA = 4'b0000;
    rst();
    doTick(80);
    chk("a80_x", xA, 400);
    chk("a80_y", yA, 398);
    chk("a80_hit", hA, 4'b0100);
    doTick(17);
    chk("a97_x", xA, 485);
    chk("a97_y", yA, 313);
    chk("a97_hit", hA, 4'b1000);
    doTick(1);
    chk("a98_x", xA, 480);
    chk("a98_y", yA, 308);
    modeA = 1'b0;
    repeat (3) @(posedge CLOCK);
    modeA = 1'b1;
    doTick(1);
    chk("glitch_x", xA, 475);
    chk("glitch_y", yA, 303);
    chk("glitch_mov", mA, 1);
    modeA = 1'b0;
    doTick(1);
    chk("toP_x", xA, 475);
    chk("toP_y", yA, 303);
    chk("toP_mov", mA, 0);
    chk("toP_hit", hA, 0);
    dirsA = 4'b1000;
    doTick(1);
    chk("player_x", xA, 480);
    chk("player_y", yA, 303);
    modeA = 1'b1;
    doTick(1);
    chk("toB_x", xA, 480);
    chk("toB_mov", mA, 0);
    doTick(1);
    chk("resume_x", xA, 485);
    chk("resume_y", yA, 308);
    chk("resume_hit", hA, 4'b1000);
    chk("resume_mov", mA, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
